// File: rtl/audio_pkg.sv
// Shared types and constants for the WM8978 I2S DAC transmit path.
// Optional build macro: AUD_MONO_DUP_EN (left sample duplicated into the right slot).
package audio_pkg;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned FRAME_W     = 32;
  localparam int unsigned FIFO_RD_LAT = 1;
  localparam int unsigned BITCNT_W    = $clog2(32 + 1);

  // One stereo frame as stored in the receive cache: left in the upper half.
  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;

  // Sample that feeds the right-channel slot.
  function automatic logic [SAMPLE_W-1:0] right_sample(input frame_t f);
`ifdef AUD_MONO_DUP_EN
    return f.left;
`else
    return f.right;
`endif
  endfunction

endpackage

// File: rtl/aud_lrc_edge_det.sv
// LRC edge detector, slave to the codec's LRC.
// Ports:
//   aud_bclk_i      bit clock, rising edge
//   rst_i           synchronous active-high reset
//   aud_lrc_i       codec LRC (0 = left, 1 = right)
//   left_start_c_o  combinational pulse: falling LRC edge seen this cycle
//   right_start_c_o combinational pulse: rising LRC edge seen this cycle
module aud_lrc_edge_det (
  input  logic aud_bclk_i,
  input  logic rst_i,
  input  logic aud_lrc_i,
  output logic left_start_c_o,
  output logic right_start_c_o
);

  logic lrc_d0_q;
  logic primed_q;
  logic edge_c;

  // primed masks the first cycle after reset, where lrc_d0 still holds its reset value.
  always_ff @(posedge aud_bclk_i) begin
    if (rst_i) begin
      lrc_d0_q <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      lrc_d0_q <= aud_lrc_i;
      primed_q <= 1'b1;
    end
  end

  assign edge_c          = primed_q && (aud_lrc_i != lrc_d0_q);
  assign left_start_c_o  = edge_c && !aud_lrc_i;
  assign right_start_c_o = edge_c && aud_lrc_i;

endmodule

// File: rtl/audio_dac_i2s_tx.sv
// I2S transmitter toward the WM8978 DAC, in the codec bit-clock domain.
// Requests one stereo frame per LRC period from the receive cache on the
// right-channel edge and serialises it MSB-first, one BCLK after each LRC edge.
// Optional build macro: AUD_MONO_DUP_EN (right slot carries the left sample).
// Ports:
//   aud_bclk     bit clock, all logic on its rising edge
//   rst          synchronous active-high reset
//   aud_lrc      codec LRC (0 = left, 1 = right)
//   dac_data     cache read data, [31:16] left, [15:0] right
//   aud_dac_req  one-cycle cache read request
//   aud_dacdat   serial DAC data
//   frame_done   one-cycle pulse when a new frame starts transmitting
module audio_dac_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned WL = 32
) (
  input  logic                aud_bclk,
  input  logic                rst,
  input  logic                aud_lrc,
  input  logic [FRAME_W-1:0]  dac_data,
  output logic                aud_dac_req,
  output logic                aud_dacdat,
  output logic                frame_done
);

  localparam logic [BITCNT_W-1:0] WL_CNT = BITCNT_W'(WL);

  logic left_start;
  logic right_start;

  frame_t                  next_frame_q, next_frame_d;
  frame_t                  cur_frame_q,  cur_frame_d;
  logic [FRAME_W-1:0]      shift_q,      shift_d;
  logic [BITCNT_W-1:0]     bit_cnt_q,    bit_cnt_d;
  logic [FIFO_RD_LAT-1:0]  cap_pipe_q,   cap_pipe_d;
  logic                    req_q,  req_d;
  logic                    dat_q,  dat_d;
  logic                    done_q, done_d;
  logic [SAMPLE_W-1:0]     slot_sample;

  aud_lrc_edge_det u_edge_det (
    .aud_bclk_i      (aud_bclk),
    .rst_i           (rst),
    .aud_lrc_i       (aud_lrc),
    .left_start_c_o  (left_start),
    .right_start_c_o (right_start)
  );

  // Next-state logic: slot loading, bit shifting and frame capture.
  always_comb begin
    next_frame_d = next_frame_q;
    cur_frame_d  = cur_frame_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    dat_d        = 1'b0;
    req_d        = right_start;
    done_d       = left_start;
    slot_sample  = left_start ? next_frame_q.left : right_sample(cur_frame_q);

    // Request delay line lines the capture up with the cache read latency.
    cap_pipe_d[0] = req_q;
    for (int unsigned i = 1; i < FIFO_RD_LAT; i++) begin
      cap_pipe_d[i] = cap_pipe_q[i-1];
    end
    if (cap_pipe_q[FIFO_RD_LAT-1]) begin
      next_frame_d = dac_data;
    end

    if (left_start) begin
      cur_frame_d = next_frame_q;
    end

    // MSB goes out straight from the edge; the shifter holds the rest of the slot.
    if (left_start || right_start) begin
      dat_d     = slot_sample[SAMPLE_W-1];
      shift_d   = {slot_sample, SAMPLE_W'(0)} << 1;
      bit_cnt_d = BITCNT_W'(1);
    end else if (bit_cnt_q < WL_CNT) begin
      dat_d     = shift_q[FRAME_W-1];
      shift_d   = shift_q << 1;
      bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge aud_bclk) begin
    if (rst) begin
      next_frame_q <= '0;
      cur_frame_q  <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      cap_pipe_q   <= '0;
      req_q        <= 1'b0;
      dat_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      next_frame_q <= next_frame_d;
      cur_frame_q  <= cur_frame_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      cap_pipe_q   <= cap_pipe_d;
      req_q        <= req_d;
      dat_q        <= dat_d;
      done_q       <= done_d;
    end
  end

  assign aud_dac_req = req_q;
  assign aud_dacdat  = dat_q;
  assign frame_done  = done_q;

endmodule
